// File: rtl/mmio_uart_tx.sv
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with TX FIFO and IRQ
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic [3:0]  i_sel,
    output logic [31:0] o_rdata,
    output logic        o_txd,
    output logic        o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, tx_en_q, irq_en_q, irq_en_d;
    logic [15:0]    div_q, bitcnt_q;
    logic [2:0]     bitidx_q;
    logic [7:0]     shift_q;
    logic           txd_q, irq_q;

    logic           hit, push_req, push_ok, pop, full, empty, busy;
    logic           ctrl_we, div_we, stat_we, idle_d;
    logic [1:0]     reg_sel;

    assign hit      = (i_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel  = i_addr[3:2];
    assign push_req = i_we && hit && (reg_sel == 2'd0) && i_sel[0];
    assign stat_we  = i_we && hit && (reg_sel == 2'd1) && i_sel[0];
    assign ctrl_we  = i_we && hit && (reg_sel == 2'd2) && i_sel[0];
    assign div_we   = i_we && hit && (reg_sel == 2'd3);

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign busy     = (state_q != IDLE);
    // Push is judged on the pre-edge count; a same-cycle pop does not make room.
    assign push_ok  = push_req && !full;
    assign pop      = (state_q == IDLE) && tx_en_q && !empty;
    assign count_d  = count_q + CW'(push_ok) - CW'(pop);
    assign irq_en_d = ctrl_we ? i_wdata[1] : irq_en_q;
    assign idle_d   = ((state_q == IDLE) && !pop) ||
                      ((state_q == STOP) && (bitcnt_q == '0));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            tx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            div_q    <= DEFAULT_DIV;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (push_req && full) begin
                ovf_q <= 1'b1;
            end else if (stat_we && i_wdata[3]) begin
                ovf_q <= 1'b0;
            end
            if (ctrl_we) tx_en_q <= i_wdata[0];
            irq_en_q <= irq_en_d;
            if (div_we && i_sel[0]) div_q[7:0]  <= i_wdata[7:0];
            if (div_we && i_sel[1]) div_q[15:8] <= i_wdata[15:8];
        end
    end

    // Serialiser: bit counter reloads from DIV at each bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            txd_q    <= 1'b1;
            irq_q    <= 1'b0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            bitidx_q <= '0;
        end else begin
            irq_q <= irq_en_d && (count_d == '0) && idle_d;
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
                        bitcnt_q <= div_q;
                        txd_q    <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (bitcnt_q == '0) begin
                        bitcnt_q <= div_q;
                        bitidx_q <= '0;
                        txd_q    <= shift_q[0];
                        state_q  <= DATA;
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (bitcnt_q == '0) begin
                        bitcnt_q <= div_q;
                        if (bitidx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bitidx_q <= bitidx_q + 1'b1;
                            shift_q  <= shift_q >> 1;
                            txd_q    <= shift_q[1];
                        end
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (bitcnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_rdata = '0;
        if (hit) begin
            case (reg_sel)
                2'd1: begin
                    o_rdata[0]    = full;
                    o_rdata[1]    = empty;
                    o_rdata[2]    = busy;
                    o_rdata[3]    = ovf_q;
                    o_rdata[12:8] = 5'(count_q);
                end
                2'd2:    o_rdata[1:0]  = {irq_en_q, tx_en_q};
                2'd3:    o_rdata[15:0] = div_q;
                default: o_rdata       = '0;
            endcase
        end
    end

    assign o_txd = txd_q;
    assign o_irq = irq_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, i_addr[1:0], i_sel[3:2], i_wdata[31:16]};

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// tb_mmio_uart_tx : randomized frame checks of mmio_uart_tx against a waveform model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;
    localparam logic [15:0] DDIV  = 16'd433;
    localparam logic [31:0] A_TX  = BASE + 32'h0;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_CT  = BASE + 32'h8;
    localparam logic [31:0] A_DV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        i_we = 1'b0;
    logic [3:0]  i_sel = '0;
    logic [31:0] o_rdata;
    logic        o_txd, o_irq;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] bytes [DEPTH];

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .reset(rst), .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we),
        .i_sel(i_sel), .o_rdata(o_rdata), .o_txd(o_txd), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level k cycles after the first start bit: frames of
    // 10 bit periods separated by a single idle cycle.
    function automatic logic model_txd(int k, int n, int d);
        int bp = d + 1;
        int p  = 10 * bp + 1;
        int f  = k / p;
        int r  = k % p;
        int b;
        if (f >= n || r == 10 * bp) return 1'b1;
        b = r / bp;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return bytes[f][b-1];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        i_addr = a; i_wdata = d; i_sel = s; i_we = 1'b1;
        @(negedge clk);
        i_we = 1'b0; i_sel = '0; i_wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        i_we = 1'b0; i_addr = a;
        #1;
        d = o_rdata;
    endtask

    // Enables transmission of n already-queued bytes and checks every cycle.
    task automatic run_frames(input int n, input int d, input bit irq);
        int t;
        logic [31:0] v;
        logic etx, eirq;
        wr(A_CT, irq ? 32'd3 : 32'd1, 4'b0001);
        vectors++;
        if (o_txd !== 1'b1) begin
            miscompares++; $display("FAIL pre_start_txd: got %b expected 1", o_txd);
        end
        t = n * (10 * (d + 1) + 1) - 1;
        for (int k = 0; k <= t + 2; k++) begin
            @(negedge clk);
            etx  = model_txd(k, n, d);
            eirq = irq && (k >= t);
            vectors++;
            if (o_txd !== etx) begin
                miscompares++; $display("FAIL txd[k=%0d n=%0d d=%0d]: got %b expected %b", k, n, d, o_txd, etx);
            end
            vectors++;
            if (o_irq !== eirq) begin
                miscompares++; $display("FAIL irq[k=%0d]: got %b expected %b", k, o_irq, eirq);
            end
        end
        rd(A_ST, v);
        vectors++;
        if (v !== 32'h2) begin
            miscompares++; $display("FAIL status_after_frames: got %h expected 00000002", v);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd(A_ST, v); vectors++;
        if (v !== 32'h2) begin miscompares++; $display("FAIL reset_status: got %h expected 00000002", v); end
        rd(A_CT, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 00000000", v); end
        rd(A_DV, v); vectors++;
        if (v !== {16'h0, DDIV}) begin miscompares++; $display("FAIL reset_div: got %h expected %h", v, {16'h0, DDIV}); end
        rd(A_TX, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_txdata_read: got %h expected 00000000", v); end
        vectors++;
        if (o_txd !== 1'b1 || o_irq !== 1'b0) begin
            miscompares++; $display("FAIL reset_pins: got txd=%b irq=%b expected txd=1 irq=0", o_txd, o_irq);
        end
    endtask

    task automatic test_window;
        logic [31:0] v;
        rd(BASE + 32'h14, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL window_read_14: got %h expected 00000000", v); end
        rd(BASE - 32'h4, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL window_read_below: got %h expected 00000000", v); end
        wr(BASE + 32'h10, 32'hA5, 4'hF);
        wr(BASE + 32'h14, 32'hFF, 4'hF);
        wr(BASE + 32'h18, 32'h3, 4'hF);
        wr(BASE + 32'h1C, 32'h1234, 4'hF);
        rd(A_ST, v); vectors++;
        if (v !== 32'h2) begin miscompares++; $display("FAIL window_status: got %h expected 00000002", v); end
        rd(A_CT, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL window_ctrl: got %h expected 00000000", v); end
        rd(A_DV, v); vectors++;
        if (v !== {16'h0, DDIV}) begin miscompares++; $display("FAIL window_div: got %h expected %h", v, {16'h0, DDIV}); end
    endtask

    task automatic test_regs;
        logic [31:0] v;
        wr(A_DV, 32'hFFFF_ABCD, 4'b0010);
        rd(A_DV, v); vectors++;
        if (v !== {16'h0, 8'hAB, DDIV[7:0]}) begin
            miscompares++; $display("FAIL div_lane1: got %h expected %h", v, {16'h0, 8'hAB, DDIV[7:0]});
        end
        wr(A_DV, 32'hFFFF_12EF, 4'b0001);
        rd(A_DV, v); vectors++;
        if (v !== 32'h0000_ABEF) begin miscompares++; $display("FAIL div_lane0: got %h expected 0000abef", v); end
        wr(A_CT, 32'hFFFF_FFFE, 4'b0001);
        rd(A_CT, v); vectors++;
        if (v !== 32'h2) begin miscompares++; $display("FAIL ctrl_write: got %h expected 00000002", v); end
        wr(A_CT, 32'hFFFF_FFFF, 4'b1110);
        rd(A_CT, v); vectors++;
        if (v !== 32'h2) begin miscompares++; $display("FAIL ctrl_nosel: got %h expected 00000002", v); end
        wr(A_CT, 32'h0, 4'b0001);
    endtask

    task automatic test_basic;
        logic [31:0] v;
        logic e;
        wr(A_DV, 32'd3, 4'b0011);
        wr(A_CT, 32'd1, 4'b0001);
        bytes[0] = 8'h55;
        wr(A_TX, 32'h55, 4'b0001);
        rd(A_ST, v); vectors++;
        if (v !== 32'h100 || o_txd !== 1'b1) begin
            miscompares++; $display("FAIL basic_after_push: got status=%h txd=%b expected 00000100 txd=1", v, o_txd);
        end
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            e = model_txd(k, 1, 3);
            vectors++;
            if (o_txd !== e) begin miscompares++; $display("FAIL basic_txd[k=%0d]: got %b expected %b", k, o_txd, e); end
        end
        rd(A_ST, v); vectors++;
        if (v !== 32'h2) begin miscompares++; $display("FAIL basic_idle_status: got %h expected 00000002", v); end
        wr(A_CT, 32'd0, 4'b0001);
    endtask

    task automatic test_overflow;
        logic [31:0] v;
        wr(A_CT, 32'd0, 4'b0001);
        wr(A_DV, 32'd0, 4'b0011);
        for (int i = 0; i < DEPTH + 1; i++) begin
            v = $urandom;
            if (i < DEPTH) bytes[i] = v[7:0];
            wr(A_TX, v, 4'b0001);
        end
        rd(A_ST, v); vectors++;
        if (v !== 32'h809) begin miscompares++; $display("FAIL ovf_status: got %h expected 00000809", v); end
        wr(A_ST, 32'h8, 4'b0010);
        rd(A_ST, v); vectors++;
        if (v !== 32'h809) begin miscompares++; $display("FAIL ovf_clear_nosel: got %h expected 00000809", v); end
        wr(A_ST, 32'h8, 4'b0001);
        rd(A_ST, v); vectors++;
        if (v !== 32'h801) begin miscompares++; $display("FAIL ovf_clear: got %h expected 00000801", v); end
        run_frames(DEPTH, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        wr(A_CT, 32'd0, 4'b0001);
        wr(A_DV, 32'd1, 4'b0011);
        bytes[0] = 8'hA0; bytes[1] = 8'h0F;
        wr(A_TX, 32'hA0, 4'b0001);
        wr(A_TX, 32'h0F, 4'b0001);
        run_frames(2, 1, 1'b1);
        vectors++;
        if (o_irq !== 1'b1) begin miscompares++; $display("FAIL irq_held: got %b expected 1", o_irq); end
        wr(A_CT, 32'd1, 4'b0001);
        vectors++;
        if (o_irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", o_irq); end
        wr(A_CT, 32'd0, 4'b0001);
    endtask

    task automatic test_random;
        int n, d;
        bit irq;
        logic [31:0] v;
        for (int it = 0; it < 4; it++) begin
            n   = $urandom_range(1, DEPTH);
            d   = $urandom_range(0, 3);
            irq = 1'($urandom_range(0, 1));
            wr(A_CT, 32'd0, 4'b0001);
            wr(A_DV, d, 4'b0011);
            for (int i = 0; i < n; i++) begin
                v = $urandom;
                bytes[i] = v[7:0];
                wr(A_TX, v, 4'b0001);
            end
            run_frames(n, d, irq);
        end
        wr(A_CT, 32'd0, 4'b0001);
    endtask

    task automatic test_tx_en_stop;
        logic [31:0] v;
        wr(A_DV, 32'd1, 4'b0011);
        wr(A_TX, $urandom, 4'b0001);
        wr(A_TX, 32'h00, 4'b0001);
        wr(A_CT, 32'd1, 4'b0001);
        repeat (4) @(negedge clk);
        wr(A_CT, 32'd0, 4'b0001);
        rd(A_ST, v); vectors++;
        if (v !== 32'h104) begin miscompares++; $display("FAIL txen_midframe: got %h expected 00000104", v); end
        repeat (30) @(negedge clk);
        rd(A_ST, v); vectors++;
        if (v !== 32'h100 || o_txd !== 1'b1) begin
            miscompares++; $display("FAIL txen_stop: got status=%h txd=%b expected 00000100 txd=1", v, o_txd);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] v;
        wr(A_DV, 32'd3, 4'b0011);
        wr(A_CT, 32'd1, 4'b0001);
        repeat (22) @(negedge clk);
        vectors++;
        if (o_txd !== 1'b0) begin miscompares++; $display("FAIL midframe_bit4: got %b expected 0", o_txd); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (o_txd !== 1'b1 || o_irq !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_pins: got txd=%b irq=%b expected txd=1 irq=0", o_txd, o_irq);
        end
        @(negedge clk);
        rst = 1'b0;
        rd(A_ST, v); vectors++;
        if (v !== 32'h2) begin miscompares++; $display("FAIL midreset_status: got %h expected 00000002", v); end
        rd(A_DV, v); vectors++;
        if (v !== {16'h0, DDIV}) begin miscompares++; $display("FAIL midreset_div: got %h expected %h", v, {16'h0, DDIV}); end
        repeat (5) @(negedge clk);
        vectors++;
        if (o_txd !== 1'b1) begin miscompares++; $display("FAIL no_resume: got %b expected 1", o_txd); end
    endtask

    initial begin
        test_reset();
        test_window();
        test_regs();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_random();
        test_tx_en_stop();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
